// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, instruction field positions and
// the opcode/func encodings the decoder consumes.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    VALID
  } fetch_state_e;

  localparam logic [5:0] op_type_r = 6'b000000;
  localparam logic [5:0] op_addiu  = 6'b001001;
  localparam logic [5:0] op_sw     = 6'b101011;
  localparam logic [5:0] op_jal    = 6'b000011;
  localparam logic [5:0] func_addu = 6'b100001;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem over req/ack, hands words to the
// decoder over valid/ready. FETCH_ALIGN_CHECK_EN adds a sticky misalign flag.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [5:0]         func,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc_plus4,
  output logic               fetch_misalign
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic [ADDR_W-1:0]  rpc;
  logic [ADDR_W-1:0]  pc_inc;

  assign rpc    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc = pc_q + ADDR_W'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    req_d      = req_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc4_d      = pc4_q;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = rpc;
        req_addr_d = pc_d;
        req_d      = 1'b1;
        state_d    = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            // wrong-path data is dropped; a fresh request starts next cycle
            pc_d       = rpc;
            req_addr_d = rpc;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc4_d      = pc_inc;
            pc_d       = pc_inc;
            req_d      = 1'b0;
            valid_d    = 1'b1;
            state_d    = VALID;
          end
        end else if (redirect) begin
          // the bus transaction cannot be cancelled; keep req_addr until ack
          pc_d    = rpc;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = rpc;
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = FETCH;
        end
      end
      VALID: begin
        if (redirect) begin
          pc_d       = rpc;
          req_addr_d = rpc;
          req_d      = 1'b1;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end else if (instr_ready) begin
          req_addr_d = pc_q;
          req_d      = 1'b1;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc4_q      <= ADDR_W'(4);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc4_q      <= pc4_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = req_addr_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign func           = instr_q[FUNC_MSB:FUNC_LSB];
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = pc4_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) mis_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign fetch_misalign = mis_q;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a program-order PC model with a latency-randomized memory responder.
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  bit rand_lat = 1'b0;
  int waited = 0;
  int lat_cur = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .func(func), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2409_0005;
    if (a == 32'h4) return 32'h0000_0000;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: acks after lat_cur waiting cycles, data looked up from mem_word.
  always @(negedge clk) begin
    if (imem_ack || !imem_req) begin
      waited  = 0;
      lat_cur = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
    end
    if (imem_req && waited >= lat_cur) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack = 1'b0;
      if (imem_req) waited++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 0;
    rand_lat = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        fetch_misalign !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h mis=%b addr=%h want 0s",
               imem_req, instr_valid, instr, instr_pc, fetch_misalign, imem_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: imem_req=%b want 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    logic [31:0] got [3];
    int n = 0;
    bit seen = 1'b0;
    mem_lat = 0;
    do_reset();
    instr_ready = 1'b1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      step();
      if (instr_valid && !seen) begin
        seen = 1'b1;
        checks++;
        if (instr !== 32'h2409_0005 || opcode !== 6'b001001 || func !== 6'b000101 ||
            instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) begin
          errors++;
          $display("FAIL first_instr: instr=%h op=%b func=%b pc=%h pc4=%h want 24090005 001001 000101 0 4",
                   instr, opcode, func, instr_pc, instr_pc_plus4);
        end
      end
      if (imem_req && imem_ack) begin
        got[n] = imem_addr;
        n++;
      end
    end
    instr_ready = 1'b0;
    checks++;
    if (n != 3 || !seen) begin
      errors++;
      $display("FAIL first_fetch_timeout: acks=%0d seen_valid=%b want 3 1", n, seen);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 32'(4 * i)) begin
          errors++;
          $display("FAIL seq_addr%0d: got %h want %h", i, got[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hi, hp;
    bit found = 1'b0;
    mem_lat = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_wait_valid: no instr_valid within 10 cycles");
      return;
    end
    hi = instr;
    hp = instr_pc;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== hi || instr_pc !== hp || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b instr=%h pc=%h req=%b want 1 %h %h 0",
                 instr_valid, instr, instr_pc, imem_req, hi, hp);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b want 1 00000004 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bit acked = 1'b0;
    bit found = 1'b0;
    mem_lat = 3;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold: req=%b addr=%h valid=%b want 1 00000000 0",
                 imem_req, imem_addr, instr_valid);
      end
      if (imem_ack) begin
        acked = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL drain_timeout: no ack within 10 cycles");
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_refetch: req=%b addr=%h valid=%b want 1 00000100 0",
               imem_req, imem_addr, instr_valid);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL drain_deliver: found=%b pc=%h instr=%h want 1 00000100 %h",
               found, instr_pc, instr, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_ack();
    mem_lat = 0;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL ack_redirect: valid=%b req=%b addr=%h want 0 1 00000200",
               instr_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      errors++;
      $display("FAIL ack_redirect_deliver: valid=%b pc=%h want 1 00000200", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL valid_redirect: valid=%b req=%b addr=%h want 0 1 00000300",
               instr_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin
      errors++;
      $display("FAIL valid_redirect_deliver: valid=%b pc=%h want 1 00000300", instr_valid, instr_pc);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 0;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_instr: valid=%b pc=%h pc4=%h want 1 fffffffc 00000000",
               instr_valid, instr_pc, instr_pc_plus4);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL wrap_deliver: valid=%b pc=%h pc4=%h want 1 0 4", instr_valid, instr_pc, instr_pc_plus4);
    end
  endtask

  task automatic test_misalign();
    mem_lat = 0;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_misalign !== MIS_EN) begin
      errors++;
      $display("FAIL misalign_set: req=%b addr=%h mis=%b want 1 00000100 %b",
               imem_req, imem_addr, fetch_misalign, MIS_EN);
    end
    step();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    instr_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (fetch_misalign !== MIS_EN) begin
        errors++;
        $display("FAIL misalign_sticky: mis=%b want %b", fetch_misalign, MIS_EN);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b want 0", fetch_misalign);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = '0;
    logic        exp_mis = 1'b0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
    logic [31:0] p_addr = '0, p_instr = '0, p_ipc = '0;
    int          xfers = 0;
    rand_lat = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (p_req && !p_ack) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          errors++;
          $display("FAIL rnd_req_hold: req=%b addr=%h want 1 %h", imem_req, imem_addr, p_addr);
        end
      end
      if (p_valid && !p_ready && !p_redir) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== p_instr || instr_pc !== p_ipc) begin
          errors++;
          $display("FAIL rnd_valid_hold: valid=%b instr=%h pc=%h want 1 %h %h",
                   instr_valid, instr, instr_pc, p_instr, p_ipc);
        end
      end
      if (instr_valid) begin
        checks++;
        if (instr !== mem_word(instr_pc) || opcode !== instr[31:26] || func !== instr[5:0] ||
            instr_pc_plus4 !== 32'(instr_pc + 32'd4)) begin
          errors++;
          $display("FAIL rnd_fields: instr=%h pc=%h op=%b func=%b pc4=%h want instr %h",
                   instr, instr_pc, opcode, func, instr_pc_plus4, mem_word(instr_pc));
        end
      end
      checks++;
      if (fetch_misalign !== exp_mis) begin
        errors++;
        $display("FAIL rnd_misalign: mis=%b want %b", fetch_misalign, exp_mis);
      end
      instr_ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom);
      // architectural view of the coming edge: redirect retargets, transfer advances
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        if (redirect_pc[1:0] != 2'b00) exp_mis = MIS_EN;
      end else if (instr_valid && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc) begin
          errors++;
          $display("FAIL rnd_order: pc=%h want %h", instr_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      p_req   = imem_req;
      p_ack   = imem_ack;
      p_addr  = imem_addr;
      p_valid = instr_valid;
      p_ready = instr_ready;
      p_redir = redirect;
      p_instr = instr;
      p_ipc   = instr_pc;
      step();
    end
    redirect = 1'b0;
    instr_ready = 1'b0;
    rand_lat = 1'b0;
    checks++;
    if (xfers < 100) begin
      errors++;
      $display("FAIL rnd_progress: transfers=%0d want >=100", xfers);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the MIPS core. It owns the PC and issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction, already split into opcode/func, to the decoder through a valid/ready interface. It accepts PC redirects (jal and future branches) and discards any in-flight or buffered wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
ADDR_W, 32, width of PC and memory address.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  read request; held high until ack.
imem_addr  output  ADDR_W  word address of the request; stable while imem_req is high.
imem_ack  input  1  read completes at a rising edge where imem_req=1 and imem_ack=1.
imem_rdata  input  32  read data; valid in the ack cycle.
redirect  input  1  load a new PC this cycle.
redirect_pc  input  ADDR_W  target PC.
instr_valid  output  1  instruction available to the decoder.
instr_ready  input  1  decoder accepts the instruction.
instr  output  32  fetched word.
opcode  output  6  instr[31:26], to decoder.opcode.
func  output  6  instr[5:0], to decoder.func.
instr_pc  output  ADDR_W  address of instr.
instr_pc_plus4  output  ADDR_W  instr_pc+4, used as the link source.
fetch_misalign  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (async assert): state=IDLE, pc=RESET_PC, req_addr=RESET_PC. imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_misalign=0.
- All outputs are registered. opcode and func are wire slices of the instr register.
- IDLE: outputs idle for one cycle after reset release, then go to FETCH. A redirect in IDLE loads pc.
- FETCH: imem_req=1, imem_addr=req_addr=pc.
  - ack and no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, go to VALID.
  - ack and redirect: drop the data, pc<=redirect_pc, stay in FETCH with the new address next cycle.
  - redirect without ack: the memory transaction cannot be aborted. pc<=redirect_pc, req_addr is unchanged, go to DRAIN.
  - Neither: hold.
- DRAIN: imem_req=1 with the old req_addr.
  - Every redirect here overwrites pc; the last one wins.
  - On ack: discard the data, go to FETCH using pc.
- VALID: instr_valid=1.
  - Redirect has priority over the handshake. On redirect, the instruction is dropped even if instr_ready=1: instr_valid<=0, pc<=redirect_pc, go to FETCH.
  - instr_ready without redirect: transfer completes, instr_valid<=0, go to FETCH.
  - Otherwise: hold; instr, instr_pc and valid stay stable.
- Throughput: at most 1 instruction per 2 cycles; minimum latency is 1 cycle from ack to instr_valid.
- PC arithmetic: modulo 2^ADDR_W. pc=0xFFFF_FFFC increments to 0x0000_0000 with no flag.
- redirect_pc[1:0] is always forced to 2'b00 before loading.
- imem_req never drops without an ack, including when a redirect arrives.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 on the next edge. The flag stays set until rst; the address is still forced aligned.
- Undefined: the check logic is absent and fetch_misalign is tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum {IDLE, FETCH, DRAIN, VALID};
  - opcode and func constants (op_type_r, op_addiu, op_sw, op_jal, func_addu);
  - INSTR_W=32 and the field bit positions.
- No sub-module; the FSM and the PC datapath are a single always_ff plus output assigns.

Test Plan:
1. Reset release with memory acking on the first req cycle, returning 0x2409_0005, 0x0000_0000, ... and instr_ready=1 → imem_addr sequence 0x0, 0x4, 0x8. First instr=0x2409_0005, opcode=6'b001001, instr_pc=0, instr_pc_plus4=4.
2. instr_ready held 0 for 5 cycles in VALID → instr and instr_pc stable, no new imem_req. Ready=1 → next req at 0x4.
3. Redirect to 0x100 while FETCH waits 3 cycles for ack → imem_addr stays at the old address until ack, data is dropped, next req at 0x100, no instr_valid for the dropped word.
4. Redirect to 0x200 in the same cycle as ack, and redirect to 0x300 in VALID with ready=1 → no transfer occurs for either; subsequent reqs go to 0x200 and 0x300 respectively.
5. Redirect to 0xFFFF_FFFC, then fetch twice → addresses 0xFFFF_FFFC then 0x0000_0000.
6. With FETCH_ALIGN_CHECK_EN: redirect_pc=0x103 → imem_addr=0x100 and fetch_misalign=1 until rst. Without the macro: fetch_misalign stays 0.
